// File: rtl/draw_triangle_stream.sv
// Bresenham outline rasteriser: triangle V0->V1->V2->V0 or line P0->P1, one pixel per cycle.
// First pixel two cycles after START, one SETUP bubble per edge; pixel outputs hold while PX_READY is low.
module draw_triangle_stream #(
  parameter int CW = 8
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic          START,
  input  logic          MODE,
  input  logic [CW-1:0] X0,
  input  logic [CW-1:0] Y0,
  input  logic [CW-1:0] X1,
  input  logic [CW-1:0] Y1,
  input  logic [CW-1:0] X2,
  input  logic [CW-1:0] Y2,
  output logic          BUSY,
  output logic          PX_VALID,
  input  logic          PX_READY,
  output logic [CW-1:0] PX_X,
  output logic [CW-1:0] PX_Y,
  output logic          PX_LAST,
  output logic          DONE
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EMIT, S_FIN} state_t;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t               state_q;
  logic                 mode_q, sx_q, sy_q, busy_q, valid_q, done_q;
  logic [1:0]           edge_q, last_edge_q;
  logic [2:0][CW-1:0]   vx_q, vy_q;
  logic [CW-1:0]        x_q, y_q, bx_q, by_q;
  logic signed [CW:0]   dx_q, dy_q;
  logic signed [CW+1:0] err_q;

  logic [CW-1:0]        ax, ay, bx, by, adx, ady, x_d, y_d;
  logic signed [CW:0]   dx_s, dy_s;
  logic signed [CW+1:0] err_s, err_d;
  logic signed [CW+2:0] e2, dx_e, dy_e;
  logic                 step_x, step_y, zero_edge, is_final, is_last, all_eq;
  logic [1:0]           last_edge_s;

  // Endpoints of the current edge; line mode always uses edge 0 = (V0,V1).
  always_comb begin
    ax = vx_q[0];
    ay = vy_q[0];
    bx = vx_q[1];
    by = vy_q[1];
    case (edge_q)
      2'd1: begin
        ax = vx_q[1]; ay = vy_q[1]; bx = vx_q[2]; by = vy_q[2];
      end
      2'd2: begin
        ax = vx_q[2]; ay = vy_q[2]; bx = vx_q[0]; by = vy_q[0];
      end
      default: ;
    endcase
    adx       = (bx >= ax) ? (bx - ax) : (ax - bx);
    ady       = (by >= ay) ? (by - ay) : (ay - by);
    dx_s      = {1'b0, adx};
    dy_s      = {(CW+1){1'b0}} - {1'b0, ady};
    err_s     = {dx_s[CW], dx_s} + {dy_s[CW], dy_s};
    zero_edge = (ax == bx) && (ay == by);
  end

  always_comb begin
    e2     = {err_q, 1'b0};
    dx_e   = {{2{dx_q[CW]}}, dx_q};
    dy_e   = {{2{dy_q[CW]}}, dy_q};
    step_x = (e2 >= dy_e);
    step_y = (e2 <= dx_e);
    x_d    = x_q;
    y_d    = y_q;
    err_d  = err_q;
    if (step_x) begin
      x_d   = sx_q ? (x_q + ONE) : (x_q - ONE);
      err_d = err_d + {dy_q[CW], dy_q};
    end
    if (step_y) begin
      y_d   = sy_q ? (y_q + ONE) : (y_q - ONE);
      err_d = err_d + {dx_q[CW], dx_q};
    end
    // Triangle edges stop one short of B so shared vertices are emitted once.
    is_final = mode_q ? ((x_q == bx_q) && (y_q == by_q))
                      : ((x_d == bx_q) && (y_d == by_q));
    is_last  = is_final && (edge_q == last_edge_q);
  end

  // An all-equal triangle runs as a zero-length line so V0 is still emitted once.
  always_comb begin
    all_eq      = (X0 == X1) && (X1 == X2) && (Y0 == Y1) && (Y1 == Y2);
    last_edge_s = 2'd2;
    if (MODE || all_eq)
      last_edge_s = 2'd0;
    else if ((X2 == X0) && (Y2 == Y0))
      last_edge_s = 2'd1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      edge_q      <= 2'd0;
      last_edge_q <= 2'd0;
      vx_q        <= '0;
      vy_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_FIN: begin
          state_q <= S_IDLE;
          if (START) begin
            vx_q        <= {X2, X1, X0};
            vy_q        <= {Y2, Y1, Y0};
            mode_q      <= MODE || all_eq;
            edge_q      <= 2'd0;
            last_edge_q <= last_edge_s;
            busy_q      <= 1'b1;
            state_q     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (!mode_q && zero_edge) begin
            if (edge_q == last_edge_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              edge_q <= edge_q + 2'd1;
            end
          end else begin
            x_q     <= ax;
            y_q     <= ay;
            bx_q    <= bx;
            by_q    <= by;
            dx_q    <= dx_s;
            dy_q    <= dy_s;
            err_q   <= err_s;
            sx_q    <= (bx >= ax);
            sy_q    <= (by >= ay);
            valid_q <= 1'b1;
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (valid_q && PX_READY) begin
            if (!is_final) begin
              x_q   <= x_d;
              y_q   <= y_d;
              err_q <= err_d;
            end else if (is_last) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              valid_q <= 1'b0;
              edge_q  <= edge_q + 2'd1;
              state_q <= S_SETUP;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BUSY     = busy_q;
  assign PX_VALID = valid_q;
  assign PX_X     = x_q;
  assign PX_Y     = y_q;
  assign PX_LAST  = valid_q && is_last;
  assign DONE     = done_q;

endmodule

// File: tb/tb_draw_triangle_stream.sv
// Table of rasteriser commands with expected pixel lists; a queue scoreboard checks each transfer.
// Hand sequences cover reset state, START overlap and reset abort.
module tb_draw_triangle_stream;
  localparam int CW = 8;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          START = 1'b0;
  logic          MODE = 1'b0;
  logic          PX_READY = 1'b0;
  logic [CW-1:0] X0 = '0, Y0 = '0, X1 = '0, Y1 = '0, X2 = '0, Y2 = '0;
  logic          BUSY, PX_VALID, PX_LAST, DONE;
  logic [CW-1:0] PX_X, PX_Y;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       last;
  } pix_t;

  typedef struct {
    logic       mode;
    logic [7:0] x0, y0, x1, y1, x2, y2;
    int         lo;
    int         n;
    int         rdy_pct;
    int         lat;
    int         bub;
    bit         poke;
  } vec_t;

  pix_t ptab[$];
  vec_t vecs[$];
  pix_t exp_q[$];

  draw_triangle_stream #(.CW(CW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START), .MODE(MODE),
    .X0(X0), .Y0(Y0), .X1(X1), .Y1(Y1), .X2(X2), .Y2(Y2),
    .BUSY(BUSY), .PX_VALID(PX_VALID), .PX_READY(PX_READY),
    .PX_X(PX_X), .PX_Y(PX_Y), .PX_LAST(PX_LAST), .DONE(DONE)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
    end
  endtask

  task automatic add_pix(input int x, input int y, input bit l);
    pix_t p;
    p.x = 8'(x);
    p.y = 8'(y);
    p.last = l;
    ptab.push_back(p);
  endtask

  task automatic add_vec(input logic m, input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int lo, input int n,
                         input int pct, input int lat, input int bub, input bit poke);
    vec_t v;
    v.mode = m;
    v.x0 = 8'(ax); v.y0 = 8'(ay); v.x1 = 8'(bx); v.y1 = 8'(by); v.x2 = 8'(cx); v.y2 = 8'(cy);
    v.lo = lo; v.n = n; v.rdy_pct = pct; v.lat = lat; v.bub = bub; v.poke = poke;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int   k, first, bubbles, xfers, last_k;
    bit   stall_prev, early_done, timed_out;
    pix_t held, got, e;
    for (int i = 0; i < v.n; i++) exp_q.push_back(ptab[v.lo + i]);
    @(negedge ACLK);
    MODE = v.mode;
    X0 = v.x0; Y0 = v.y0; X1 = v.x1; Y1 = v.y1; X2 = v.x2; Y2 = v.y2;
    START = 1'b1;
    PX_READY = 1'b0;
    @(negedge ACLK);
    START = 1'b0;
    k = 1; first = -1; bubbles = 0; xfers = 0; last_k = -1;
    stall_prev = 0; early_done = 0; timed_out = 1;
    held = '0;
    chk("busy_after_start", BUSY, 1);
    chk("valid_in_setup", PX_VALID, 0);
    while (k < 2000) begin
      if (v.poke) begin
        START = (k == 5);
        if (k == 5) begin
          MODE = ~v.mode;
          X0 = 8'hAA; Y0 = 8'h55; X1 = 8'h11; Y1 = 8'h22; X2 = 8'h33; Y2 = 8'h44;
        end
      end
      PX_READY = (v.rdy_pct >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
      got = {PX_X, PX_Y, PX_LAST};
      if (stall_prev) chk("stall_hold", {PX_VALID, got}, {1'b1, held});
      if (PX_VALID && first < 0) first = k;
      if (first >= 0 && !PX_VALID && xfers < v.n) bubbles++;
      if (DONE && xfers < v.n) early_done = 1;
      if (last_k >= 0 && k == last_k + 1) begin
        chk("done_pulse", DONE, 1);
        chk("busy_fall", BUSY, 0);
      end
      if (last_k >= 0 && k == last_k + 2) begin
        chk("done_single_cycle", DONE, 0);
        timed_out = 0;
        break;
      end
      if (PX_VALID && PX_READY) begin
        if (exp_q.size() == 0) chk("extra_pixel_count", xfers + 1, v.n);
        else begin
          e = exp_q.pop_front();
          chk("pixel_x_y_last", got, e);
        end
        xfers++;
        if (xfers == v.n) last_k = k;
      end
      stall_prev = PX_VALID && !PX_READY;
      held = got;
      @(negedge ACLK);
      k++;
    end
    START = 1'b0;
    PX_READY = 1'b0;
    if (timed_out) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: transfers %0d required %0d within cycle budget", xfers, v.n);
    end
    chk("first_valid_latency", first, v.lat);
    chk("setup_bubbles", bubbles, v.bub);
    chk("transfer_count", xfers, v.n);
    chk("no_early_done", early_done, 0);
    exp_q.delete();
  endtask

  initial begin
    int  lo, xf, cnt;
    bit  done_seen;

    // Line (2,3)->(7,3)
    lo = ptab.size();
    for (int i = 2; i <= 7; i++) add_pix(i, 3, i == 7);
    add_vec(1'b1, 2, 3, 7, 3, 0, 0, lo, 6, 100, 2, 0, 0);
    // Triangle (0,0),(4,0),(0,4)
    lo = ptab.size();
    for (int i = 0; i < 4; i++) add_pix(i, 0, 0);
    for (int i = 0; i < 4; i++) add_pix(4 - i, i, 0);
    for (int i = 4; i >= 1; i--) add_pix(0, i, i == 1);
    add_vec(1'b0, 0, 0, 4, 0, 0, 4, lo, 12, 100, 2, 2, 0);
    add_vec(1'b0, 0, 0, 4, 0, 0, 4, lo, 12, 50, 2, 2, 1);
    // Degenerate triangle
    lo = ptab.size();
    add_pix(9, 9, 1);
    add_vec(1'b0, 9, 9, 9, 9, 9, 9, lo, 1, 100, 2, 0, 0);
    // Triangle whose first edge has zero length
    lo = ptab.size();
    add_pix(1, 1, 0); add_pix(2, 2, 0); add_pix(3, 2, 0); add_pix(4, 3, 0);
    add_pix(5, 3, 0); add_pix(4, 2, 0); add_pix(3, 2, 0); add_pix(2, 1, 1);
    add_vec(1'b0, 1, 1, 1, 1, 5, 3, lo, 8, 100, 3, 1, 0);
    // Full-range diagonals
    lo = ptab.size();
    for (int i = 0; i < 256; i++) add_pix(i, i, i == 255);
    add_vec(1'b1, 0, 0, 255, 255, 0, 0, lo, 256, 100, 2, 0, 0);
    lo = ptab.size();
    for (int i = 0; i < 256; i++) add_pix(255 - i, i, i == 255);
    add_vec(1'b1, 255, 0, 0, 255, 0, 0, lo, 256, 100, 2, 0, 0);

    #12;
    chk("reset_busy", BUSY, 0);
    chk("reset_valid", PX_VALID, 0);
    chk("reset_x", PX_X, 0);
    chk("reset_y", PX_Y, 0);
    chk("reset_last", PX_LAST, 0);
    chk("reset_done", DONE, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort a triangle with reset while its fifth pixel is presented.
    @(negedge ACLK);
    MODE = 1'b0;
    X0 = 8'd0; Y0 = 8'd0; X1 = 8'd4; Y1 = 8'd0; X2 = 8'd0; Y2 = 8'd4;
    START = 1'b1;
    PX_READY = 1'b1;
    @(negedge ACLK);
    START = 1'b0;
    xf = 0;
    cnt = 0;
    while (!(PX_VALID && xf == 4) && cnt < 100) begin
      if (PX_VALID && PX_READY) xf++;
      @(negedge ACLK);
      cnt++;
    end
    chk("abort_reached_pixel5", xf, 4);
    chk("abort_pixel5_xy", {PX_X, PX_Y}, {8'd4, 8'd0});
    PX_READY = 1'b0;
    ARESETN = 1'b0;
    #1;
    chk("abort_busy", BUSY, 0);
    chk("abort_valid", PX_VALID, 0);
    chk("abort_x", PX_X, 0);
    chk("abort_y", PX_Y, 0);
    chk("abort_last", PX_LAST, 0);
    chk("abort_done", DONE, 0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      done_seen |= DONE;
    end
    ARESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      done_seen |= DONE;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_idle_busy", BUSY, 0);

    run_vec(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/draw_triangle_stream.md
# draw_triangle_stream

Parametrised Bresenham rasteriser that generates the pixel coordinates of a triangle outline (three edges, V0→V1→V2→V0) or a single line (P0→P1). It is the successor of the 8-bit free-running triangle walker. It adds a configurable coordinate width, a START/BUSY/DONE command handshake, and a backpressured VALID/READY pixel stream. It sits between the command decoder and the framebuffer write port.

## Interface
Parameters:
- CW, default 8: coordinate width in bits (unsigned), legal range 4–16.

Ports:
- ACLK  in  1  clock; everything is sampled on the rising edge.
- ARESETN  in  1  reset; asynchronous assertion, active-low.
- START  in  1  command strobe; sampled only in IDLE.
- MODE  in  1  0 = triangle outline; 1 = single line X0,Y0→X1,Y1 (X2/Y2 are ignored).
- X0, Y0, X1, Y1, X2, Y2  in  CW each  vertex coordinates; latched when START is accepted.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- PX_VALID  out  1  a pixel is presented.
- PX_READY  in  1  the consumer accepts the pixel; a transfer occurs when VALID & READY.
- PX_X, PX_Y  out  CW each  pixel coordinate.
- PX_LAST  out  1  marks the final pixel of the command.
- DONE  out  1  single-cycle pulse after the final transfer.

## Operation
- States:
  - IDLE: waits for START.
  - SETUP: computes edge parameters for the current edge.
  - EMIT: presents a pixel and steps on each transfer.
  - FIN: pulses DONE, then returns to IDLE.
- START & IDLE: latch the vertices and MODE, set the edge index to 0, then go to SETUP.
- START while BUSY is ignored; the latched vertices are unaffected by input changes during the command.
- Edge list:
  - Triangle: (V0,V1), (V1,V2), (V2,V0). Each edge emits its start point and excludes its end point, so no pixel repeats. This includes V0, which is emitted only once.
  - Line: one edge that emits both endpoints inclusive.
- SETUP arithmetic, on edge (A,B):
  - dx = |Bx−Ax|, dy = −|By−Ay|, computed in CW+1 bits signed.
  - sx, sy = ±1.
  - err = dx+dy, held in CW+2 bits signed.
  - Cursor = A.
  - If the edge length is zero (A == B) in triangle mode, the edge is skipped: advance to the next edge's SETUP with no pixel.
- EMIT step, on a transfer when the cursor is not the final pixel of the edge:
  - e2 = 2·err.
  - If e2 ≥ dy: err += dy and x += sx.
  - If e2 ≤ dx: err += dx and y += sy.
  - The cursor must never wrap; intermediate values stay within the signed widths above.
- Edge end:
  - Triangle: the final pixel is the one whose next step would equal B.
  - Line: the final pixel is B itself.
  - After the edge's final transfer, go to SETUP for the next edge. After the last edge, go to FIN.
- PX_LAST is asserted with the last pixel of the last non-skipped edge (line mode: P1).
- Degenerate triangle (all vertices equal): emit exactly one pixel, V0, with PX_LAST.
- Stream rule: while PX_VALID & !PX_READY, PX_X, PX_Y and PX_LAST hold stable and PX_VALID stays high.

## Timing
- Reset values: BUSY=0, PX_VALID=0, PX_X=0, PX_Y=0, PX_LAST=0, DONE=0, state IDLE.
- Reset asserted mid-command aborts the command immediately; no DONE is produced.
- Pipeline:
  - Cycle 0: START is accepted.
  - Cycle 1: SETUP, with BUSY=1.
  - Cycle 2: first PX_VALID.
- Throughput: one pixel per cycle while PX_READY=1.
- Each edge transition inserts exactly one SETUP bubble (PX_VALID=0). A skipped edge costs one additional cycle.
- DONE is asserted in the cycle after the PX_LAST transfer. BUSY falls in that same cycle.
- A new START is accepted from the cycle DONE is high onward (FIN counts as idle for START).

## Test plan
- Line mode, CW=8, (2,3)→(7,3), READY=1: 6 pixels x=2..7, y=3; PX_LAST on (7,3); DONE 1 cycle later; first VALID 2 cycles after START.
- Triangle (0,0),(4,0),(0,4): 12 pixels.
  - Edge 1: (0,0)..(3,0).
  - Edge 2: (4,0),(3,1),(2,2),(1,3).
  - Edge 3: (0,4)..(0,1), with PX_LAST on (0,1).
  - One bubble before each of edges 2 and 3.
- Random PX_READY (50%) on the same triangle: identical pixel sequence; outputs stable during stalls; DONE only after the 12th transfer.
- Degenerate triangle (9,9)×3: one pixel (9,9) with PX_LAST; DONE follows.
- Line (0,0)→(255,255), CW=8: 256 diagonal pixels; no wrap.
- Line (255,0)→(0,255), CW=8: 256 anti-diagonal pixels; no wrap.
- Overlap and abort:
  - START pulsed mid-command: ignored.
  - ARESETN low at pixel 5 of a triangle: all outputs 0 immediately, no DONE.
  - A subsequent START runs a fresh command correctly.
